// File: rtl/multicycle_mult_unit_pkg.sv
// Shared types and sizing helpers for the iterative EX-stage multiplier.
package multicycle_mult_unit_pkg;

    // FSM encoding; the values are fixed so the hazard unit and debug taps agree on them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

    // Default configuration: 32-bit datapath built over 4 accumulate cycles.
    localparam int MUL_DATA_W   = 32;
    localparam int MUL_N_CYCLES = 4;

    // Width of the multiplier slice consumed per cycle.
    function automatic int chunk_w(input int data_w, input int n_cycles);
        return data_w / n_cycles;
    endfunction

    // Cycle counter width: clog2(n_cycles), never narrower than one bit.
    function automatic int cnt_w(input int n_cycles);
        return (n_cycles > 1) ? $clog2(n_cycles) : 1;
    endfunction

    localparam int CHUNK_W = chunk_w(MUL_DATA_W, MUL_N_CYCLES);
    localparam int CNT_W   = cnt_w(MUL_N_CYCLES);

endpackage

// File: rtl/multicycle_mult_unit_mult_chunk_mac.sv
// One partial-product step: acc + ((a * b_chunk) << (idx*CHUNK_W)), kept to DATA_W bits.
module mult_chunk_mac
    import multicycle_mult_unit_pkg::*;
#(
    parameter int DATA_W  = MUL_DATA_W,
    parameter int CHUNK_W = 8,
    parameter int CNT_W   = 2
) (
    input  logic [DATA_W-1:0]  a_i,
    input  logic [CHUNK_W-1:0] chunk_i,
    input  logic [CNT_W-1:0]   idx_i,
    input  logic [DATA_W-1:0]  acc_i,
    output logic [DATA_W-1:0]  acc_o
);

    logic [DATA_W-1:0] prod;
    logic [DATA_W-1:0] prod_sh;

    // Truncating before the shift is safe: only the low DATA_W bits ever survive.
    always_comb begin
        prod    = a_i * DATA_W'(chunk_i);
        prod_sh = prod << (32'(idx_i) * CHUNK_W);
        acc_o   = acc_i + prod_sh;
    end

endmodule

// File: rtl/multicycle_mult_unit.sv
// Iterative MUL for the EX stage: latches operands, accumulates one multiplier
// slice per cycle, and stalls the front of the pipeline until the product is ready.
module multicycle_mult_unit
    import multicycle_mult_unit_pkg::*;
#(
    parameter int DATA_W   = MUL_DATA_W,
    parameter int N_CYCLES = MUL_N_CYCLES
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              stall_request,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    localparam int CHW = chunk_w(DATA_W, N_CYCLES);
    localparam int CW  = cnt_w(N_CYCLES);

    localparam logic [CW-1:0] LAST_CNT = CW'(N_CYCLES - 1);

    mul_state_e        state_q;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic              result_valid_q;
    logic [CHW-1:0]    b_chunk;

    // Select the multiplier slice for the current accumulate step.
    always_comb begin
        b_chunk = b_q[32'(count_q) * CHW +: CHW];
    end

    mult_chunk_mac #(
        .DATA_W  (DATA_W),
        .CHUNK_W (CHW),
        .CNT_W   (CW)
    ) u_mac (
        .a_i     (a_q),
        .chunk_i (b_chunk),
        .idx_i   (count_q),
        .acc_i   (acc_q),
        .acc_o   (acc_d)
    );

    // Control FSM with operand, accumulator, result and valid registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            acc_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    result_valid_q <= 1'b0;
                    // A flushed MUL never gets its operands latched.
                    if (start && !flush) begin
                        a_q     <= operand_a;
                        b_q     <= operand_b;
                        acc_q   <= '0;
                        count_q <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        // Abandon the partial product; result keeps the last good value.
                        result_valid_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end else begin
                        acc_q   <= acc_d;
                        count_q <= count_q + CW'(1);
                        if (count_q == LAST_CNT) begin
                            result_q       <= acc_d;
                            result_valid_q <= 1'b1;
                            state_q        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // start is still high for the same MUL here, so never restart from DONE.
                    result_valid_q <= 1'b0;
                    state_q        <= ST_IDLE;
                end
                default: begin
                    result_valid_q <= 1'b0;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall: requested as soon as a MUL shows up, held through BUSY, released in DONE.
    always_comb begin
        stall_request = 1'b0;
        if (arst_n) begin
            case (state_q)
                ST_IDLE: stall_request = start;
                ST_BUSY: stall_request = 1'b1;
                default: stall_request = 1'b0;
            endcase
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_multicycle_mult_unit.sv
// Scoreboard bench for multicycle_mult_unit: expected products are queued when a
// MUL is issued and popped when result_valid is seen.
module tb_multicycle_mult_unit;

    localparam int DW   = 32;
    localparam int MAXC = 30;

    logic          clk;
    logic          arst_n;
    logic          start;
    logic          flush;
    logic [DW-1:0] operand_a;
    logic [DW-1:0] operand_b;
    logic          stall_request;
    logic [DW-1:0] result;
    logic          result_valid;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] sb_q[$];

    multicycle_mult_unit #(.DATA_W(DW), .N_CYCLES(4)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .start         (start),
        .flush         (flush),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .stall_request (stall_request),
        .result        (result),
        .result_valid  (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one MUL, hold start while stalled, return stall count and the result seen.
    task automatic do_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output int stalls, output logic [DW-1:0] res, output bit got);
        stalls = 0;
        got    = 1'b0;
        res    = '0;
        @(negedge clk);
        start     = 1'b1;
        operand_a = a;
        operand_b = b;
        sb_q.push_back(a * b);
        for (int i = 0; i < MAXC; i++) begin
            #1;
            if (stall_request) stalls++;
            if (result_valid) begin
                got = 1'b1;
                res = result;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; start = 1'b1; flush = 1'b0;
        operand_a = 32'd7; operand_b = 32'd6;
        #12;
        checks++;
        if (stall_request !== 1'b0 || result_valid !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b valid=%b result=%h, want 0/0/0",
                     stall_request, result_valid, result);
        end
        start = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (stall_request !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: stall=%b valid=%b, want 0/0", stall_request, result_valid);
        end
    endtask

    task automatic test_basic();
        int st; logic [DW-1:0] r; bit got; logic [DW-1:0] exp;
        do_mul(32'd7, 32'd6, st, r, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL basic_timeout: no result_valid within %0d cycles", MAXC);
        end
        exp = sb_q.pop_front();
        checks++;
        if (r !== exp) begin
            errors++; $display("FAIL basic_result: got %h want %h", r, exp);
        end
        checks++;
        if (st !== 5) begin
            errors++; $display("FAIL basic_stall_len: got %0d want 5", st);
        end
        checks++;
        if (stall_request !== 1'b0) begin
            errors++; $display("FAIL basic_stall_in_done: got %b want 0", stall_request);
        end
        @(negedge clk); #1;
        checks++;
        if (result_valid !== 1'b0 || result !== 32'd42) begin
            errors++;
            $display("FAIL basic_one_pulse: valid=%b result=%h want 0/0000002a", result_valid, result);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] av[4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [DW-1:0] bv[4] = '{32'hFFFF_FFFF, 32'd2, 32'h9ABC_DEF0, 32'hCAFE_F00D};
        int st; logic [DW-1:0] r; bit got; logic [DW-1:0] exp;
        for (int i = 0; i < 4; i++) begin
            do_mul(av[i], bv[i], st, r, got);
            exp = sb_q.pop_front();
            checks++;
            if (!got || r !== exp) begin
                errors++;
                $display("FAIL overflow_%0d: got %h (valid=%b) want %h", i, r, got, exp);
            end
        end
        // Hand-derived anchors for the two wrap cases.
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, st, r, got);
        void'(sb_q.pop_front());
        checks++;
        if (r !== 32'h0000_0001) begin
            errors++; $display("FAIL ones_squared: got %h want 00000001", r);
        end
        do_mul(32'h8000_0000, 32'd2, st, r, got);
        void'(sb_q.pop_front());
        checks++;
        if (r !== 32'h0000_0000) begin
            errors++; $display("FAIL msb_times2: got %h want 00000000", r);
        end
    endtask

    task automatic test_random();
        int st; logic [DW-1:0] r; bit got; logic [DW-1:0] exp;
        for (int i = 0; i < 6; i++) begin
            do_mul($urandom, $urandom, st, r, got);
            exp = sb_q.pop_front();
            checks++;
            if (!got || r !== exp || st !== 5) begin
                errors++;
                $display("FAIL random_%0d: got %h stalls=%0d want %h stalls=5", i, r, st, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses; bit done2; logic [DW-1:0] exp;
        pulses = 0; done2 = 1'b0;
        @(negedge clk);
        start = 1'b1; operand_a = 32'd11; operand_b = 32'd13;
        sb_q.push_back(32'd11 * 32'd13);
        for (int i = 0; i < MAXC && !done2; i++) begin
            #1;
            if (result_valid) begin
                pulses++;
                exp = sb_q.pop_front();
                checks++;
                if (result !== exp) begin
                    errors++; $display("FAIL b2b_result_%0d: got %h want %h", pulses, result, exp);
                end
                if (pulses == 1) begin
                    // start stays high: the next IDLE cycle launches the second MUL.
                    operand_a = 32'd3; operand_b = 32'd5;
                    sb_q.push_back(32'd15);
                    @(negedge clk); #1;
                    checks++;
                    if (result_valid !== 1'b0 || stall_request !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_gap: valid=%b stall=%b want 0/1", result_valid, stall_request);
                    end
                end else begin
                    done2 = 1'b1;
                end
            end
            if (!done2) @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (pulses !== 2) begin
            errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses);
        end
        @(negedge clk); #1;
        checks++;
        if (result !== 32'd15 || result_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_hold: result=%h valid=%b want 0000000f/0", result, result_valid);
        end
    endtask

    task automatic test_flush();
        int st; logic [DW-1:0] r; bit got; int vpulses;
        do_mul(32'd7, 32'd6, st, r, got);
        void'(sb_q.pop_front());
        // start+flush in IDLE: stall mirrors start, but nothing launches.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; operand_a = 32'd9; operand_b = 32'd9;
        #1;
        checks++;
        if (stall_request !== 1'b1) begin
            errors++; $display("FAIL idle_flush_stall: got %b want 1", stall_request);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0; #1;
        checks++;
        if (stall_request !== 1'b0) begin
            errors++; $display("FAIL idle_flush_no_launch: stall=%b want 0", stall_request);
        end
        // Launch 9*9, flush in the second BUSY cycle.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; #1;
        checks++;
        if (stall_request !== 1'b1) begin
            errors++; $display("FAIL busy_flush_stall: got %b want 1", stall_request);
        end
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        vpulses = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (result_valid) vpulses++;
            @(negedge clk);
        end
        checks++;
        if (vpulses !== 0 || result !== 32'd42 || stall_request !== 1'b0) begin
            errors++;
            $display("FAIL busy_flush: pulses=%0d result=%h stall=%b want 0/0000002a/0",
                     vpulses, result, stall_request);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; operand_a = 32'd5; operand_b = 32'd5;
        @(negedge clk);
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if (stall_request !== 1'b0 || result !== '0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL midbusy_reset: stall=%b result=%h valid=%b want 0/0/0",
                     stall_request, result, result_valid);
        end
        start = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (stall_request !== 1'b0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: stall=%b valid=%b want 0/0", stall_request, result_valid);
        end
    endtask

    task automatic test_operand_hold();
        bit got; logic [DW-1:0] exp;
        got = 1'b0;
        @(negedge clk);
        start = 1'b1; operand_a = 32'd12; operand_b = 32'd12;
        sb_q.push_back(32'd144);
        @(negedge clk);
        operand_a = 32'd100; operand_b = 32'd7;
        for (int i = 0; i < MAXC && !got; i++) begin
            #1;
            if (result_valid) begin
                got = 1'b1;
                exp = sb_q.pop_front();
                checks++;
                if (result !== exp) begin
                    errors++; $display("FAIL operand_hold: got %h want %h", result, exp);
                end
            end
            if (!got) @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL operand_hold_timeout: no result_valid within %0d cycles", MAXC);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_operand_hold();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
